mod_addsub_ctrl: RTL and testbench

//  Modular add/subtract sequencer sitting directly upstream of mpadder in the RSA datapath.

---
 rtl/mod_addsub_ctrl_if.sv | 38 +++
 rtl/mod_addsub_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mod_addsub_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mod_addsub_ctrl_if.sv
// Bundle of the request/result signals and the mpadder operand/result signals of mod_addsub_ctrl.
// Latency: n/a (wires only).
// Backpressure: n/a. The request side uses start/busy: start is only honoured while busy is low.
//
// Ports (as interface members):
//   start, subtract, in_a, in_b, in_n  request from the exponentiation control
//   result, done, busy                 modular result and status back to it
//   add_start, add_subtract, add_a, add_b  operands driven to mpadder
//   add_result                         WIDTH+1-bit sum/difference from mpadder
interface mod_addsub_ctrl_if #(
    parameter int WIDTH = 1027
);
    logic             start;
    logic             subtract;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_n;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;
    logic             add_start;
    logic             add_subtract;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH:0]   add_result;

    // Sequencer side.
    modport slave (
        input  start, subtract, in_a, in_b, in_n, add_result,
        output result, done, busy, add_start, add_subtract, add_a, add_b
    );

    // Requester and adder side.
    modport master (
        output start, subtract, in_a, in_b, in_n, add_result,
        input  result, done, busy, add_start, add_subtract, add_a, add_b
    );
endinterface

// File: rtl/mod_addsub_ctrl.sv
// Modular add/sub sequencer: R = (A+B) mod N or (A-B) mod N via a raw pass and a correction pass on one mpadder.
// Latency: start accepted in cycle 0, done pulses in cycle 2*ADD_LAT+1; next start accepted the cycle after done.
// Backpressure: start is ignored while busy is high (operation in flight); no stall once accepted.
//
// Ports: clk, resetn (async active-low), bus (mod_addsub_ctrl_if.slave) carrying the request,
// result and the mpadder operand/result signals. All outputs on bus are registered.
module mod_addsub_ctrl #(
    parameter int WIDTH   = 1027,
    parameter int ADD_LAT = 1
) (
    input  logic              clk,
    input  logic              resetn,
    mod_addsub_ctrl_if.slave  bus
);

    // Pass timer counts ADD_LAT-1 down to 0; the adder result is captured at 0.
    localparam int             CW       = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [CW-1:0]  CNT_LOAD = CW'(ADD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q,     state_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic             sub_q,       sub_d;        // operation type latched at accept
    logic [WIDTH-1:0] n_q,         n_d;          // modulus latched at accept
    logic [WIDTH:0]   p1_q,        p1_d;         // raw pass result incl. carry/borrow bit
    logic [WIDTH-1:0] result_q,    result_d;
    logic             done_q,      done_d;
    logic             busy_q,      busy_d;
    logic             add_start_q, add_start_d;
    logic             add_sub_q,   add_sub_d;
    logic [WIDTH-1:0] add_a_q,     add_a_d;
    logic [WIDTH-1:0] add_b_q,     add_b_d;

    // Final selection, evaluated on the last cycle of the correction pass.
    // Add: S-N borrowing means S was already < N, so keep S; otherwise take S-N.
    // Sub: A-B borrowing means the raw difference wrapped, so take D+N; otherwise keep D.
    logic [WIDTH-1:0] final_sel;
    always_comb begin
        final_sel = p1_q[WIDTH-1:0];
        if (sub_q) begin
            if (p1_q[WIDTH]) begin
                final_sel = bus.add_result[WIDTH-1:0];
            end
        end else begin
            if (!bus.add_result[WIDTH]) begin
                final_sel = bus.add_result[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sub_d       = sub_q;
        n_d         = n_q;
        p1_d        = p1_q;
        result_d    = result_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        add_start_d = 1'b0;
        add_sub_d   = add_sub_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sub_d       = bus.subtract;
                    n_d         = bus.in_n;
                    add_a_d     = bus.in_a;
                    add_b_d     = bus.in_b;
                    add_sub_d   = bus.subtract;
                    add_start_d = 1'b1;
                    busy_d      = 1'b1;
                    cnt_d       = CNT_LOAD;
                    state_d     = PASS1;
                end
            end

            PASS1: begin
                if (cnt_q == '0) begin
                    // Capture raw result and set up the correction pass against N;
                    // the correction direction is the opposite of the raw operation.
                    p1_d        = bus.add_result;
                    add_a_d     = bus.add_result[WIDTH-1:0];
                    add_b_d     = n_q;
                    add_sub_d   = ~sub_q;
                    add_start_d = 1'b1;
                    cnt_d       = CNT_LOAD;
                    state_d     = PASS2;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            PASS2: begin
                if (cnt_q == '0) begin
                    result_d = final_sel;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            DONE: begin
                // start is not looked at here, so the earliest next accept is the following cycle.
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sub_q       <= 1'b0;
            n_q         <= '0;
            p1_q        <= '0;
            result_q    <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            add_start_q <= 1'b0;
            add_sub_q   <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sub_q       <= sub_d;
            n_q         <= n_d;
            p1_q        <= p1_d;
            result_q    <= result_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            add_start_q <= add_start_d;
            add_sub_q   <= add_sub_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
        end
    end

    assign bus.result       = result_q;
    assign bus.done         = done_q;
    assign bus.busy         = busy_q;
    assign bus.add_start    = add_start_q;
    assign bus.add_subtract = add_sub_q;
    assign bus.add_a        = add_a_q;
    assign bus.add_b        = add_b_q;

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Directed bench for mod_addsub_ctrl with a combinational mpadder model.
// Latency: two instances, ADD_LAT=1 (u1) and ADD_LAT=3 (u3).
// Backpressure: exercises start-while-busy and start held high.
module tb_mod_addsub_ctrl;
    localparam int W = 1027;

    logic clk;
    logic resetn;
    int   tests_run;
    int   fails;

    mod_addsub_ctrl_if #(.WIDTH(W)) if1 ();
    mod_addsub_ctrl_if #(.WIDTH(W)) if3 ();

    mod_addsub_ctrl #(.WIDTH(W), .ADD_LAT(1)) u1 (.clk(clk), .resetn(resetn), .bus(if1));
    mod_addsub_ctrl #(.WIDTH(W), .ADD_LAT(3)) u3 (.clk(clk), .resetn(resetn), .bus(if3));

    // mpadder model: plain WIDTH+1-bit add/sub of the registered operands.
    assign if1.add_result = if1.add_subtract ? ({1'b0, if1.add_a} - {1'b0, if1.add_b})
                                             : ({1'b0, if1.add_a} + {1'b0, if1.add_b});
    assign if3.add_result = if3.add_subtract ? ({1'b0, if3.add_a} - {1'b0, if3.add_b})
                                             : ({1'b0, if3.add_a} + {1'b0, if3.add_b});

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one op on u1 starting from IDLE; returns result, cycles to done, timeout flag.
    // Ends in the cycle after done, where a new start may be presented.
    task automatic do_op1(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] n, output logic [W-1:0] res,
                          output int lat, output bit to);
        if1.start    = 1'b1;
        if1.subtract = s;
        if1.in_a     = a;
        if1.in_b     = b;
        if1.in_n     = n;
        tick();
        lat = 1;
        if1.start = 1'b0;
        while (if1.done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        to  = (if1.done !== 1'b1);
        res = if1.result;
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) tick();
        tests_run++; if (if1.result !== '0) begin fails++; $display("FAIL reset_result: got %0d want 0", if1.result); end
        tests_run++; if (if1.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", if1.done); end
        tests_run++; if (if1.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", if1.busy); end
        tests_run++; if (if1.add_start !== 1'b0 || if1.add_subtract !== 1'b0) begin
            fails++; $display("FAIL reset_add_ctl: got start=%b sub=%b want 0 0", if1.add_start, if1.add_subtract); end
        tests_run++; if (if1.add_a !== '0 || if1.add_b !== '0) begin
            fails++; $display("FAIL reset_add_ops: got a=%0d b=%0d want 0 0", if1.add_a, if1.add_b); end
        resetn = 1'b1;
        tick();
    endtask

    // N=13, A=7, B=9 add: cycle-by-cycle check of the two passes.
    task automatic test_add_timing();
        if1.start = 1'b1; if1.subtract = 1'b0;
        if1.in_a = W'(7); if1.in_b = W'(9); if1.in_n = W'(13);
        tick(); // cycle 1
        if1.start = 1'b0;
        tests_run++; if (if1.busy !== 1'b1 || if1.done !== 1'b0 || if1.add_start !== 1'b1) begin
            fails++; $display("FAIL c1_status: got busy=%b done=%b add_start=%b want 1 0 1", if1.busy, if1.done, if1.add_start); end
        tests_run++; if (if1.add_a !== W'(7) || if1.add_b !== W'(9) || if1.add_subtract !== 1'b0) begin
            fails++; $display("FAIL c1_ops: got a=%0d b=%0d sub=%b want 7 9 0", if1.add_a, if1.add_b, if1.add_subtract); end
        tick(); // cycle 2
        tests_run++; if (if1.busy !== 1'b1 || if1.done !== 1'b0 || if1.add_start !== 1'b1) begin
            fails++; $display("FAIL c2_status: got busy=%b done=%b add_start=%b want 1 0 1", if1.busy, if1.done, if1.add_start); end
        tests_run++; if (if1.add_a !== W'(16) || if1.add_b !== W'(13) || if1.add_subtract !== 1'b1) begin
            fails++; $display("FAIL c2_ops: got a=%0d b=%0d sub=%b want 16 13 1", if1.add_a, if1.add_b, if1.add_subtract); end
        tick(); // cycle 3
        tests_run++; if (if1.done !== 1'b1 || if1.busy !== 1'b1 || if1.add_start !== 1'b0) begin
            fails++; $display("FAIL c3_status: got done=%b busy=%b add_start=%b want 1 1 0", if1.done, if1.busy, if1.add_start); end
        tests_run++; if (if1.result !== W'(3)) begin fails++; $display("FAIL c3_result: got %0d want 3", if1.result); end
        tick(); // cycle 4
        tests_run++; if (if1.done !== 1'b0 || if1.busy !== 1'b0) begin
            fails++; $display("FAIL c4_idle: got done=%b busy=%b want 0 0", if1.done, if1.busy); end
    endtask

    task automatic test_add_patterns();
        logic [W-1:0] r; int lat; bit to;
        do_op1(1'b0, W'(2), W'(3), W'(13), r, lat, to);
        tests_run++; if (to || r !== W'(5) || lat != 3) begin
            fails++; $display("FAIL add_2_3: got %0d lat=%0d to=%b want 5 lat=3", r, lat, to); end
        do_op1(1'b0, W'(6), W'(7), W'(13), r, lat, to);
        tests_run++; if (to || r !== W'(0) || lat != 3) begin
            fails++; $display("FAIL add_6_7: got %0d lat=%0d to=%b want 0 lat=3", r, lat, to); end
    endtask

    task automatic test_sub();
        logic [W-1:0] r; int lat; bit to;
        do_op1(1'b1, W'(3), W'(9), W'(13), r, lat, to);
        tests_run++; if (to || r !== W'(7) || lat != 3) begin
            fails++; $display("FAIL sub_3_9: got %0d lat=%0d to=%b want 7 lat=3", r, lat, to); end
        do_op1(1'b1, W'(9), W'(3), W'(13), r, lat, to);
        tests_run++; if (to || r !== W'(6)) begin
            fails++; $display("FAIL sub_9_3: got %0d to=%b want 6", r, to); end
        do_op1(1'b1, W'(5), W'(5), W'(13), r, lat, to);
        tests_run++; if (to || r !== W'(0)) begin
            fails++; $display("FAIL sub_5_5: got %0d to=%b want 0", r, to); end
    endtask

    // start pulsed in cycles 1 and 2 with other operands must be ignored.
    task automatic test_busy_ignore();
        int ndone;
        ndone = 0;
        if1.start = 1'b1; if1.subtract = 1'b0;
        if1.in_a = W'(7); if1.in_b = W'(9); if1.in_n = W'(13);
        tick(); // cycle 1
        if1.subtract = 1'b1; if1.in_a = W'(1); if1.in_b = W'(2); if1.in_n = W'(11);
        tick(); // cycle 2
        if1.subtract = 1'b0; if1.in_a = W'(10); if1.in_b = W'(10); if1.in_n = W'(12);
        tick(); // cycle 3
        if1.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (if1.done === 1'b1) ndone++;
            tick();
        end
        tests_run++; if (ndone != 1) begin fails++; $display("FAIL busy_done_count: got %0d want 1", ndone); end
        tests_run++; if (if1.result !== W'(3) || if1.busy !== 1'b0) begin
            fails++; $display("FAIL busy_result_held: got %0d busy=%b want 3 0", if1.result, if1.busy); end
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] r; int lat; bit to; int ndone;
        ndone = 0;
        if1.start = 1'b1; if1.subtract = 1'b0;
        if1.in_a = W'(4); if1.in_b = W'(3); if1.in_n = W'(13);
        tick(); // cycle 1
        if1.start = 1'b0;
        tick(); // cycle 2, PASS2
        resetn = 1'b0;
        #1;
        tests_run++; if (if1.busy !== 1'b0 || if1.done !== 1'b0 || if1.add_start !== 1'b0 || if1.add_subtract !== 1'b0) begin
            fails++; $display("FAIL rst_mid_ctl: got busy=%b done=%b add_start=%b add_sub=%b want all 0",
                              if1.busy, if1.done, if1.add_start, if1.add_subtract); end
        tests_run++; if (if1.result !== '0 || if1.add_a !== '0 || if1.add_b !== '0) begin
            fails++; $display("FAIL rst_mid_data: got result=%0d a=%0d b=%0d want 0", if1.result, if1.add_a, if1.add_b); end
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (if1.done === 1'b1) ndone++;
            tick();
        end
        tests_run++; if (ndone != 0) begin fails++; $display("FAIL rst_mid_no_done: got %0d dones want 0", ndone); end
        do_op1(1'b0, W'(12), W'(12), W'(13), r, lat, to);
        tests_run++; if (to || r !== W'(11)) begin
            fails++; $display("FAIL rst_mid_after: got %0d to=%b want 11", r, to); end
    endtask

    // start held high: accepts at cycles 0 and 4, dones at 3 and 7.
    task automatic test_back_to_back();
        logic [7:0] done_mask;
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        done_mask = '0; r1 = '0; r2 = '0;
        if1.start = 1'b1; if1.subtract = 1'b0;
        if1.in_a = W'(4); if1.in_b = W'(5); if1.in_n = W'(13);
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) begin
                if1.subtract = 1'b1; if1.in_a = W'(10); if1.in_b = W'(5);
            end
            if (if1.done === 1'b1) done_mask[c] = 1'b1;
            if (c == 3) r1 = if1.result;
            if (c == 7) r2 = if1.result;
        end
        if1.start = 1'b0;
        tick();
        tests_run++; if (done_mask !== 8'b1000_1000) begin
            fails++; $display("FAIL b2b_done_cycles: got %b want 10001000", done_mask); end
        tests_run++; if (r1 !== W'(9) || r2 !== W'(5)) begin
            fails++; $display("FAIL b2b_results: got %0d,%0d want 9,5", r1, r2); end
        tick();
    endtask

    // ADD_LAT=3, N=2^1025-1, A=B=N-1 add: result N-2, done cycle 7, add_start cycles 1 and 4.
    task automatic test_wide_lat3();
        logic [W-1:0] n;
        logic [W-1:0] exp_r;
        logic [7:0]   st_mask;
        logic [7:0]   busy_mask;
        int           done_cyc;
        n = '0; n[1025] = 1'b1; n = n - W'(1);
        exp_r = n - W'(2);
        st_mask = '0; busy_mask = '0; done_cyc = -1;
        if3.start = 1'b1; if3.subtract = 1'b0;
        if3.in_a = n - W'(1); if3.in_b = n - W'(1); if3.in_n = n;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) if3.start = 1'b0;
            if (c <= 7 && if3.add_start === 1'b1) st_mask[c] = 1'b1;
            if (c <= 7 && if3.busy === 1'b1) busy_mask[c] = 1'b1;
            if (if3.done === 1'b1 && done_cyc < 0) begin
                done_cyc = c;
                tests_run++; if (if3.result !== exp_r) begin
                    fails++; $display("FAIL wide_result: got low64 %h want low64 %h", if3.result[63:0], exp_r[63:0]); end
            end
        end
        tests_run++; if (done_cyc != 7) begin fails++; $display("FAIL wide_done_cycle: got %0d want 7", done_cyc); end
        tests_run++; if (st_mask !== 8'b0001_0010) begin
            fails++; $display("FAIL wide_add_start: got %b want 00010010", st_mask); end
        tests_run++; if (busy_mask !== 8'b1111_1110) begin
            fails++; $display("FAIL wide_busy: got %b want 11111110", busy_mask); end
    endtask

    initial begin
        tests_run = 0;
        fails     = 0;
        if1.start = 1'b0; if1.subtract = 1'b0; if1.in_a = '0; if1.in_b = '0; if1.in_n = '0;
        if3.start = 1'b0; if3.subtract = 1'b0; if3.in_a = '0; if3.in_b = '0; if3.in_n = '0;
        resetn = 1'b0;
        test_reset();
        test_add_timing();
        test_add_patterns();
        test_sub();
        test_busy_ignore();
        test_reset_midop();
        test_back_to_back();
        test_wide_lat3();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
